// File: rtl/match_controller.sv
// Round/match sequencer: holds players in reset between rounds, judges hits,
// and tracks health, round clock and round wins for the HUD.
module match_controller #(
    parameter int unsigned HP_INIT      = 5,
    parameter int unsigned DMG          = 1,
    parameter int unsigned ROUND_SECS   = 60,
    parameter int unsigned FPS          = 60,
    parameter int unsigned INTRO_FRAMES = 90,
    parameter int unsigned END_FRAMES   = 120,
    parameter int unsigned WIN_ROUNDS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_hit_x1,
    input  logic [9:0] p1_hit_x2,
    input  logic [9:0] p1_hit_y1,
    input  logic [9:0] p1_hit_y2,
    input  logic [9:0] p2_hit_x1,
    input  logic [9:0] p2_hit_x2,
    input  logic [9:0] p2_hit_y1,
    input  logic [9:0] p2_hit_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
    output logic       players_rst,
    output logic [2:0] phase,
    output logic [3:0] p1_hp,
    output logic [3:0] p2_hp,
    output logic [6:0] round_time,
    output logic [1:0] p1_wins,
    output logic [1:0] p2_wins,
    output logic [1:0] round_winner,
    output logic       p1_hit,
    output logic       p2_hit
);
    localparam int unsigned CNT_W      = 16;
    localparam logic [3:0]  ATTACK_END = 4'd4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INTRO      = 3'd1,
        FIGHT      = 3'd2,
        ROUND_END  = 3'd3,
        MATCH_OVER = 3'd4
    } phase_t;

    phase_t           state_q;
    logic [CNT_W-1:0] frame_cnt;
    logic [3:0]       p1_prev;
    logic [3:0]       p2_prev;
    logic             start_prev;
    logic             p1_hit_c;
    logic             p2_hit_c;

    // Inclusive 1-D overlap; endpoints of either span may arrive swapped.
    function automatic logic span_overlap(input logic [9:0] a1, input logic [9:0] a2,
                                          input logic [9:0] b1, input logic [9:0] b2);
        logic [9:0] lo_a, hi_a, lo_b, hi_b, lo, hi;
        lo_a = (a1 < a2) ? a1 : a2;
        hi_a = (a1 < a2) ? a2 : a1;
        lo_b = (b1 < b2) ? b1 : b2;
        hi_b = (b1 < b2) ? b2 : b1;
        lo   = (lo_a > lo_b) ? lo_a : lo_b;
        hi   = (hi_a < hi_b) ? hi_a : hi_b;
        return lo <= hi;
    endfunction

    function automatic logic [3:0] hp_after_hit(input logic [3:0] hp);
        return (hp > 4'(DMG)) ? hp - 4'(DMG) : 4'd0;
    endfunction

    function automatic logic [1:0] win_inc(input logic [1:0] w);
        return (w == 2'd3) ? w : w + 2'd1;
    endfunction

    // One hit per attack: only the entry into the active frame counts.
    assign p1_hit_c = (p1_state == ATTACK_END) && (p1_prev != ATTACK_END)
                    && span_overlap(p1_hit_x1, p1_hit_x2, p2_hurt_x1, p2_hurt_x2)
                    && span_overlap(p1_hit_y1, p1_hit_y2, p2_hurt_y1, p2_hurt_y2);
    assign p2_hit_c = (p2_state == ATTACK_END) && (p2_prev != ATTACK_END)
                    && span_overlap(p2_hit_x1, p2_hit_x2, p1_hurt_x1, p1_hurt_x2)
                    && span_overlap(p2_hit_y1, p2_hit_y2, p1_hurt_y1, p1_hurt_y2);

    assign phase = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            players_rst  <= 1'b1;
            p1_hp        <= 4'(HP_INIT);
            p2_hp        <= 4'(HP_INIT);
            round_time   <= 7'(ROUND_SECS);
            p1_wins      <= 2'd0;
            p2_wins      <= 2'd0;
            round_winner <= 2'b00;
            p1_hit       <= 1'b0;
            p2_hit       <= 1'b0;
            frame_cnt    <= '0;
            p1_prev      <= 4'd0;
            p2_prev      <= 4'd0;
            start_prev   <= 1'b0;
        end else begin
            start_prev <= start;
            p1_prev    <= players_rst ? 4'd0 : p1_state;
            p2_prev    <= players_rst ? 4'd0 : p2_state;
            p1_hit     <= 1'b0;
            p2_hit     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= INTRO;
                        frame_cnt    <= '0;
                        p1_wins      <= 2'd0;
                        p2_wins      <= 2'd0;
                        p1_hp        <= 4'(HP_INIT);
                        p2_hp        <= 4'(HP_INIT);
                        round_time   <= 7'(ROUND_SECS);
                        round_winner <= 2'b00;
                    end
                end
                INTRO: begin
                    if (frame_cnt == CNT_W'(INTRO_FRAMES - 1)) begin
                        state_q     <= FIGHT;
                        frame_cnt   <= '0;
                        players_rst <= 1'b0;
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                FIGHT: begin
                    if (p1_hp == 4'd0 || p2_hp == 4'd0) begin
                        state_q     <= ROUND_END;
                        frame_cnt   <= '0;
                        players_rst <= 1'b1;
                        if (p1_hp == 4'd0 && p2_hp == 4'd0) begin
                            round_winner <= 2'b11;
                        end else if (p1_hp == 4'd0) begin
                            round_winner <= 2'b10;
                            p2_wins      <= win_inc(p2_wins);
                        end else begin
                            round_winner <= 2'b01;
                            p1_wins      <= win_inc(p1_wins);
                        end
                    end else if (round_time == 7'd0) begin
                        state_q     <= ROUND_END;
                        frame_cnt   <= '0;
                        players_rst <= 1'b1;
                        if (p1_hp > p2_hp) begin
                            round_winner <= 2'b01;
                            p1_wins      <= win_inc(p1_wins);
                        end else if (p2_hp > p1_hp) begin
                            round_winner <= 2'b10;
                            p2_wins      <= win_inc(p2_wins);
                        end else begin
                            round_winner <= 2'b11;
                        end
                    end else begin
                        p1_hit <= p1_hit_c;
                        p2_hit <= p2_hit_c;
                        if (p1_hit_c) p2_hp <= hp_after_hit(p2_hp);
                        if (p2_hit_c) p1_hp <= hp_after_hit(p1_hp);
                        if (frame_cnt == CNT_W'(FPS - 1)) begin
                            frame_cnt  <= '0;
                            round_time <= round_time - 7'd1;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                ROUND_END: begin
                    if (frame_cnt == CNT_W'(END_FRAMES - 1)) begin
                        frame_cnt <= '0;
                        if (p1_wins == 2'(WIN_ROUNDS) || p2_wins == 2'(WIN_ROUNDS)) begin
                            state_q <= MATCH_OVER;
                        end else begin
                            state_q      <= INTRO;
                            p1_hp        <= 4'(HP_INIT);
                            p2_hp        <= 4'(HP_INIT);
                            round_time   <= 7'(ROUND_SECS);
                            round_winner <= 2'b00;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                MATCH_OVER: begin
                    if (start && !start_prev) state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    players_rst <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: two instances with small timing
// parameters, one with HP_INIT=5 and one with HP_INIT=1.
module tb_match_controller;
    logic clk;
    logic rst_a, rst_b;
    logic a_start, b_start;
    logic [3:0] a_p1_state, a_p2_state, b_p1_state, b_p2_state;
    logic [9:0] h1x1, h1x2, h1y1, h1y2, h2x1, h2x2, h2y1, h2y2;
    logic [9:0] u1x1, u1x2, u1y1, u1y2, u2x1, u2x2, u2y1, u2y2;

    logic       a_prst, b_prst;
    logic [2:0] a_phase, b_phase;
    logic [3:0] a_p1_hp, a_p2_hp, b_p1_hp, b_p2_hp;
    logic [6:0] a_rt, b_rt;
    logic [1:0] a_p1_wins, a_p2_wins, b_p1_wins, b_p2_wins;
    logic [1:0] a_winner, b_winner;
    logic       a_p1_hit, a_p2_hit, b_p1_hit, b_p2_hit;

    int total = 0;
    int bad   = 0;

    match_controller #(.HP_INIT(5), .DMG(1), .ROUND_SECS(4), .FPS(3),
                       .INTRO_FRAMES(4), .END_FRAMES(3), .WIN_ROUNDS(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(a_start),
        .p1_state(a_p1_state), .p2_state(a_p2_state),
        .p1_hit_x1(h1x1), .p1_hit_x2(h1x2), .p1_hit_y1(h1y1), .p1_hit_y2(h1y2),
        .p2_hit_x1(h2x1), .p2_hit_x2(h2x2), .p2_hit_y1(h2y1), .p2_hit_y2(h2y2),
        .p1_hurt_x1(u1x1), .p1_hurt_x2(u1x2), .p1_hurt_y1(u1y1), .p1_hurt_y2(u1y2),
        .p2_hurt_x1(u2x1), .p2_hurt_x2(u2x2), .p2_hurt_y1(u2y1), .p2_hurt_y2(u2y2),
        .players_rst(a_prst), .phase(a_phase), .p1_hp(a_p1_hp), .p2_hp(a_p2_hp),
        .round_time(a_rt), .p1_wins(a_p1_wins), .p2_wins(a_p2_wins),
        .round_winner(a_winner), .p1_hit(a_p1_hit), .p2_hit(a_p2_hit)
    );

    match_controller #(.HP_INIT(1), .DMG(1), .ROUND_SECS(2), .FPS(3),
                       .INTRO_FRAMES(4), .END_FRAMES(3), .WIN_ROUNDS(2)) dut_b (
        .clk(clk), .rst(rst_b), .start(b_start),
        .p1_state(b_p1_state), .p2_state(b_p2_state),
        .p1_hit_x1(h1x1), .p1_hit_x2(h1x2), .p1_hit_y1(h1y1), .p1_hit_y2(h1y2),
        .p2_hit_x1(h2x1), .p2_hit_x2(h2x2), .p2_hit_y1(h2y1), .p2_hit_y2(h2y2),
        .p1_hurt_x1(u1x1), .p1_hurt_x2(u1x2), .p1_hurt_y1(u1y1), .p1_hurt_y2(u1y2),
        .p2_hurt_x1(u2x1), .p2_hurt_x2(u2x2), .p2_hurt_y1(u2y1), .p2_hurt_y2(u2y2),
        .players_rst(b_prst), .phase(b_phase), .p1_hp(b_p1_hp), .p2_hp(b_p2_hp),
        .round_time(b_rt), .p1_wins(b_p1_wins), .p2_wins(b_p2_wins),
        .round_winner(b_winner), .p1_hit(b_p1_hit), .p2_hit(b_p2_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_p1_state = 4'd0; a_p2_state = 4'd0;
        b_p1_state = 4'd0; b_p2_state = 4'd0;
        // P1 hitbox, P2 hitbox, P1 hurtbox; P2 hurtbox starts non-overlapping and swapped
        h1x1 = 10'd100; h1x2 = 10'd176; h1y1 = 10'd194; h1y2 = 10'd227;
        h2x1 = 10'd120; h2x2 = 10'd160; h2y1 = 10'd200; h2y2 = 10'd220;
        u1x1 = 10'd90;  u1x2 = 10'd140; u1y1 = 10'd180; u1y2 = 10'd260;
        u2x1 = 10'd506; u2x2 = 10'd457; u2y1 = 10'd180; u2y2 = 10'd260;
        tick(2);

        chk("rst_phase", a_phase, 0);
        chk("rst_players_rst", a_prst, 1);
        chk("rst_p1_hp", a_p1_hp, 5);
        chk("rst_p2_hp", a_p2_hp, 5);
        chk("rst_round_time", a_rt, 4);
        chk("rst_wins", {a_p1_wins, a_p2_wins}, 0);
        chk("rst_winner", a_winner, 0);
        chk("rst_hits", {a_p1_hit, a_p2_hit}, 0);

        rst_a = 1'b0;
        tick(1);
        chk("idle_hold", a_phase, 0);
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        chk("intro_entry", a_phase, 1);
        tick(3);
        chk("intro_hold", a_phase, 1);
        chk("intro_prst", a_prst, 1);
        tick(1);
        chk("fight_entry", a_phase, 2);
        chk("fight_prst", a_prst, 0);

        // swapped, non-overlapping hurtbox: attack edge lands nothing
        a_p1_state = 4'd4;
        tick(1);
        chk("nohit_pulse", a_p1_hit, 0);
        chk("nohit_hp", a_p2_hp, 5);
        a_p1_state = 4'd0;
        u2x1 = 10'd150; u2x2 = 10'd199;
        tick(1);
        a_p1_state = 4'd4;
        tick(1);
        chk("hit_pulse", a_p1_hit, 1);
        chk("hit_p2_hp", a_p2_hp, 4);
        chk("hit_p1_hp", a_p1_hp, 5);
        tick(1);
        chk("hold_no_pulse", a_p1_hit, 0);
        tick(1);
        chk("hold_no_rehit", a_p2_hp, 4);
        a_p1_state = 4'd0;
        tick(1);
        a_p1_state = 4'd4; a_p2_state = 4'd4;
        tick(1);
        chk("trade_p1_hit", a_p1_hit, 1);
        chk("trade_p2_hit", a_p2_hit, 1);
        chk("trade_p1_hp", a_p1_hp, 4);
        chk("trade_p2_hp", a_p2_hp, 3);
        chk("clock_after_7", a_rt, 2);
        a_p1_state = 4'd0; a_p2_state = 4'd0;
        tick(5);
        chk("clock_zero", a_rt, 0);
        chk("still_fight", a_phase, 2);
        tick(1);
        chk("timeout_phase", a_phase, 3);
        chk("timeout_winner", a_winner, 1);
        chk("timeout_p1_wins", a_p1_wins, 1);
        chk("timeout_p2_wins", a_p2_wins, 0);
        chk("end_prst", a_prst, 1);
        tick(2);
        chk("end_hold", a_phase, 3);
        tick(1);
        chk("reintro_phase", a_phase, 1);
        chk("reintro_hp", {a_p1_hp, a_p2_hp}, 8'h55);
        chk("reintro_clock", a_rt, 4);
        chk("reintro_winner", a_winner, 0);

        // second round: P1 lands one hit, then timeout again
        tick(4);
        chk("r2_fight", a_phase, 2);
        a_p1_state = 4'd4;
        tick(1);
        chk("r2_hit_hp", a_p2_hp, 4);
        a_p1_state = 4'd0;
        tick(12);
        chk("r2_end_phase", a_phase, 3);
        chk("r2_p1_wins", a_p1_wins, 2);
        tick(3);
        chk("match_over", a_phase, 4);
        chk("match_over_winner", a_winner, 1);
        tick(2);
        chk("match_over_hold", a_phase, 4);
        chk("match_over_wins", a_p1_wins, 2);
        a_start = 1'b1;
        tick(1);
        chk("restart_idle", a_phase, 0);
        tick(1);
        a_start = 1'b0;
        chk("restart_intro", a_phase, 1);
        chk("restart_wins", a_p1_wins, 0);
        tick(4);
        a_p1_state = 4'd4;
        tick(1);
        chk("r3_hit_hp", a_p2_hp, 4);
        rst_a = 1'b1;
        #1;
        chk("midrst_phase", a_phase, 0);
        chk("midrst_p2_hp", a_p2_hp, 5);
        chk("midrst_wins", {a_p1_wins, a_p2_wins}, 0);
        chk("midrst_prst", a_prst, 1);
        a_p1_state = 4'd0;
        tick(1);
        rst_a = 1'b0;

        // HP_INIT=1 instance, start held high for the whole match
        rst_b = 1'b0;
        b_start = 1'b1;
        tick(1);
        chk("b_intro", b_phase, 1);
        tick(4);
        chk("b_fight", b_phase, 2);
        b_p1_state = 4'd4; b_p2_state = 4'd4;
        tick(1);
        chk("b_ko_hp", {b_p1_hp, b_p2_hp}, 0);
        chk("b_ko_pulses", {b_p1_hit, b_p2_hit}, 3);
        chk("b_ko_still_fight", b_phase, 2);
        b_p1_state = 4'd0; b_p2_state = 4'd0;
        tick(1);
        chk("b_ko_phase", b_phase, 3);
        chk("b_ko_draw", b_winner, 3);
        chk("b_ko_wins", {b_p1_wins, b_p2_wins}, 0);
        tick(3);
        chk("b_reintro", b_phase, 1);
        chk("b_reintro_hp", {b_p1_hp, b_p2_hp}, 8'h11);

        tick(4);
        tick(6);
        chk("b_to_clock", b_rt, 0);
        chk("b_to_fight", b_phase, 2);
        tick(1);
        chk("b_to_phase", b_phase, 3);
        chk("b_to_draw", b_winner, 3);
        chk("b_to_wins", {b_p1_wins, b_p2_wins}, 0);
        tick(3);

        for (int r = 0; r < 2; r++) begin
            tick(4);
            b_p1_state = 4'd4;
            tick(1);
            chk("b_p1ko_hp", b_p2_hp, 0);
            b_p1_state = 4'd0;
            tick(1);
            chk("b_p1ko_winner", b_winner, 1);
            chk("b_p1ko_wins", b_p1_wins, r + 1);
            tick(3);
        end
        chk("b_match_over", b_phase, 4);
        tick(3);
        chk("b_level_no_retrigger", b_phase, 4);
        chk("b_wins_hold", b_p1_wins, 2);
        b_start = 1'b0;
        tick(1);
        b_start = 1'b1;
        tick(1);
        chk("b_edge_idle", b_phase, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
